// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter.
// Mode encodings, stage control bundle and reserved-mode check.
package shifter_pkg;

    typedef enum logic [2:0] {
        MODE_LSL = 3'b000,
        MODE_LSR = 3'b001,
        MODE_ASR = 3'b010,
        MODE_ROL = 3'b011,
        MODE_ROR = 3'b100
    } mode_e;

    // Data and amt ride alongside this bundle since their widths follow WIDTH.
    typedef struct packed {
        logic [2:0] mode;
        logic       carry;
        logic       err;
    } stage_ctl_t;

    function automatic logic is_reserved_mode(input logic [2:0] m);
        return m > MODE_ROR;
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// One conditional shift by DIST plus its pipeline register.
// The register holds everything, bubbles included, while adv is low.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIST = 1,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [AMT_W-1:0] amt_i,
    input  stage_ctl_t       ctl_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [AMT_W-1:0] amt_o,
    output stage_ctl_t       ctl_o,
    output logic             zero_o
);

    localparam int BIT = $clog2(DIST);

    logic             active;
    logic [WIDTH-1:0] data_d, data_q;
    logic             carry_d;
    logic             zero_d;
    logic             valid_q, zero_q;
    logic [AMT_W-1:0] amt_q;
    stage_ctl_t       ctl_q;

    assign active = amt_i[BIT] && !ctl_i.err;

    always_comb begin
        data_d  = data_i;
        carry_d = ctl_i.carry;
        if (active) begin
            unique case (ctl_i.mode)
                MODE_LSL: begin
                    data_d  = data_i << DIST;
                    carry_d = data_i[WIDTH-DIST];
                end
                MODE_LSR: begin
                    data_d  = data_i >> DIST;
                    carry_d = data_i[DIST-1];
                end
                MODE_ASR: begin
                    data_d  = $signed(data_i) >>> DIST;
                    carry_d = data_i[DIST-1];
                end
                MODE_ROL: begin
                    data_d  = {data_i[WIDTH-DIST-1:0], data_i[WIDTH-1:WIDTH-DIST]};
                    carry_d = data_i[WIDTH-DIST];
                end
                MODE_ROR: begin
                    data_d  = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
                    carry_d = data_i[DIST-1];
                end
                default: ;
            endcase
        end
        zero_d = ~|data_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            amt_q   <= '0;
            ctl_q   <= '0;
            zero_q  <= 1'b0;
        end else if (adv) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q <= data_d;
                amt_q  <= amt_i;
                ctl_q  <= '{mode: ctl_i.mode, carry: carry_d, err: ctl_i.err};
                zero_q <= zero_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign amt_o   = amt_q;
    assign ctl_o   = ctl_q;
    assign zero_o  = zero_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter/rotator, one register per log2 stage.
// A single advance enable moves the whole pipe; valid/ready on both ends.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amt,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             carry_out,
    output logic             zero,
    output logic             mode_err
);

    logic             adv;
    logic             valid_s [AMT_W+1];
    logic [WIDTH-1:0] data_s  [AMT_W+1];
    logic [AMT_W-1:0] amt_s   [AMT_W+1];
    stage_ctl_t       ctl_s   [AMT_W+1];
    logic [AMT_W-1:0] zero_s;
    logic             unused_tail;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign valid_s[0] = in_valid;
    assign data_s[0]  = data_in;
    assign amt_s[0]   = amt;
    assign ctl_s[0]   = '{mode: mode, carry: 1'b0, err: is_reserved_mode(mode)};

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        shift_stage #(
            .WIDTH(WIDTH),
            .DIST (1 << k)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .adv    (adv),
            .valid_i(valid_s[k]),
            .data_i (data_s[k]),
            .amt_i  (amt_s[k]),
            .ctl_i  (ctl_s[k]),
            .valid_o(valid_s[k+1]),
            .data_o (data_s[k+1]),
            .amt_o  (amt_s[k+1]),
            .ctl_o  (ctl_s[k+1]),
            .zero_o (zero_s[k])
        );
    end

    assign out_valid = valid_s[AMT_W];
    assign data_out  = data_s[AMT_W];
    assign carry_out = ctl_s[AMT_W].carry;
    assign mode_err  = ctl_s[AMT_W].err;
    assign zero      = zero_s[AMT_W-1];

    // Flags of earlier stages and the spent amt/mode are not needed at the output.
    assign unused_tail = ^{zero_s, amt_s[AMT_W], ctl_s[AMT_W].mode};

endmodule
